// File: rtl/mailbox_mm_pkg.sv
// Shared types and mailbox layout constants for the mailbox memory manager.
package mailbox_mm_pkg;

  // Top-level sequencing states of the mailbox manager.
  typedef enum logic [2:0] {
    IDLE,
    RD_FLAG,
    RD_BLOCK,
    WR_ACK,
    WR_NONCE,
    WR_SOLFLAG
  } state_t;

  // Encodings reported to the mining core on sol_response.
  typedef enum logic [1:0] {
    SOL_NONE     = 2'b00,
    SOL_ACCEPTED = 2'b01,
    SOL_WRITTEN  = 2'b10,
    SOL_DROPPED  = 2'b11
  } sol_resp_t;

  // Byte offsets of the mailbox fields relative to the mailbox base.
  localparam int HOST_FLAG_OFS = 0;
  localparam int HW_FLAG_OFS   = 4;
  localparam int BLOCK_OFS     = 8;

endpackage

// File: rtl/mm_txn.sv
// Single-transaction engine for the RAM controller: issues the one-cycle
// go pulse, holds command/address/data until the response, and times out.
module mm_txn #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_done,
  output logic              o_timeout,
  output logic              o_ctl_go,
  output logic              o_ctl_wr,
  output logic [ADDR_W-1:0] o_ctl_address,
  output logic [DATA_W-1:0] o_ctl_wr_data,
  input  logic              i_ctl_rd_valid,
  input  logic              i_ctl_wr_done
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic              r_busy;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_resp;

  // Only the response matching the held command type completes it. r_busy
  // rises after the go cycle, so a response coincident with go is ignored.
  assign w_resp    = r_wr ? i_ctl_wr_done : i_ctl_rd_valid;
  assign o_done    = r_busy & w_resp;
  assign o_timeout = r_busy & ~w_resp & (r_cnt == CNT_W'(TIMEOUT - 1));

  // The request register upstream is already a one-cycle pulse, so go is
  // that pulse; the command is presented directly in the go cycle and from
  // the hold registers afterwards.
  assign o_ctl_go      = i_req;
  assign o_ctl_wr      = i_req ? i_req_wr   : r_wr;
  assign o_ctl_address = i_req ? i_req_addr : r_addr;
  assign o_ctl_wr_data = i_req ? i_req_data : r_data;

  // Capture the command on request and count wait cycles until response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block based on pre-edge values, independent of statement order.
      if (i_req) begin
        r_busy <= 1'b1;
        r_wr   <= i_req_wr;
        r_addr <= i_req_addr;
        r_data <= i_req_data;
        r_cnt  <= '0;
      end else if (r_busy) begin
        if (w_resp || o_timeout) begin
          r_busy <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mailbox_mem_manager.sv
// Polls the host mailbox flag in shared memory, streams a work block to the
// mining core, acknowledges it, and writes core solutions back to memory.
module mailbox_mem_manager
  import mailbox_mm_pkg::*;
#(
  parameter int                ADDR_W      = 28,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 28'h8000000,
  parameter int                BLOCK_WORDS = 24,
  parameter logic [DATA_W-1:0] READY_MAGIC = 32'hAAAA0000,
  parameter logic [DATA_W-1:0] ACK_MAGIC   = 32'h5555AAAA,
  parameter logic [DATA_W-1:0] SOL_MAGIC   = 32'h5555F00D,
  parameter int                POLL_GAP    = 16,
  parameter int                TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ctl_go,
  output logic              ctl_wr,
  output logic [ADDR_W-1:0] ctl_address,
  output logic [DATA_W-1:0] ctl_wr_data,
  input  logic              ctl_rd_valid,
  input  logic [DATA_W-1:0] ctl_rd_data,
  input  logic              ctl_wr_done,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              start_found,
  input  logic              sol_claim,
  input  logic [DATA_W-1:0] in_data,
  output logic [1:0]        sol_response,
  output logic              err_timeout
);

  localparam int GAP_W  = $clog2(POLL_GAP) + 1;
  localparam int WORD_W = $clog2(BLOCK_WORDS) + 1;

  // Mailbox field addresses; all arithmetic wraps in ADDR_W bits.
  localparam logic [ADDR_W-1:0] HOST_FLAG_ADDR = BASE_ADDR + ADDR_W'(HOST_FLAG_OFS);
  localparam logic [ADDR_W-1:0] HW_FLAG_ADDR   = BASE_ADDR + ADDR_W'(HW_FLAG_OFS);
  localparam logic [ADDR_W-1:0] BLOCK_ADDR     = BASE_ADDR + ADDR_W'(BLOCK_OFS);
  localparam logic [ADDR_W-1:0] NONCE_ADDR     = BLOCK_ADDR + ADDR_W'(4 * BLOCK_WORDS);

  state_t            r_state;
  logic [GAP_W-1:0]  r_gap;
  logic [WORD_W-1:0] r_word;
  logic              r_req;
  logic              r_req_wr;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_req_data;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_last_word;
  logic              r_start_found;
  logic              r_sol_pending;
  logic [DATA_W-1:0] r_nonce;
  sol_resp_t         r_sol_response;
  logic              r_err_timeout;

  logic              w_done;
  logic              w_timeout;
  logic [WORD_W-1:0] w_word_next;
  logic [ADDR_W-1:0] w_next_word_addr;
  logic              w_pending_eff;

  assign w_word_next      = r_word + WORD_W'(1);
  assign w_next_word_addr = BLOCK_ADDR + (ADDR_W'(w_word_next) << 2);

  // A solution write completing this cycle frees the slot for a new claim.
  assign w_pending_eff = r_sol_pending & ~((r_state == WR_SOLFLAG) & w_done);

  mm_txn #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_txn (
    .clk            (clk),
    .reset          (reset),
    .i_req          (r_req),
    .i_req_wr       (r_req_wr),
    .i_req_addr     (r_req_addr),
    .i_req_data     (r_req_data),
    .o_done         (w_done),
    .o_timeout      (w_timeout),
    .o_ctl_go       (ctl_go),
    .o_ctl_wr       (ctl_wr),
    .o_ctl_address  (ctl_address),
    .o_ctl_wr_data  (ctl_wr_data),
    .i_ctl_rd_valid (ctl_rd_valid),
    .i_ctl_wr_done  (ctl_wr_done)
  );

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign start_found  = r_start_found;
  assign sol_response = r_sol_response;
  assign err_timeout  = r_err_timeout;

  // Mailbox sequencer with registered outputs and solution capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_gap          <= '0;
      r_word         <= '0;
      r_req          <= 1'b0;
      r_req_wr       <= 1'b0;
      r_req_addr     <= '0;
      r_req_data     <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_last_word    <= 1'b0;
      r_start_found  <= 1'b0;
      r_sol_pending  <= 1'b0;
      r_nonce        <= '0;
      r_sol_response <= SOL_NONE;
      r_err_timeout  <= 1'b0;
    end else begin
      r_req          <= 1'b0;
      r_out_valid    <= 1'b0;
      r_last_word    <= 1'b0;
      r_start_found  <= r_last_word;
      r_sol_response <= SOL_NONE;
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (r_sol_pending) begin
            r_gap      <= '0;
            r_state    <= WR_NONCE;
            r_req      <= 1'b1;
            r_req_wr   <= 1'b1;
            r_req_addr <= NONCE_ADDR;
            r_req_data <= r_nonce;
          end else if (r_gap == GAP_W'(POLL_GAP - 1)) begin
            r_gap      <= '0;
            r_state    <= RD_FLAG;
            r_req      <= 1'b1;
            r_req_wr   <= 1'b0;
            r_req_addr <= HOST_FLAG_ADDR;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end

        RD_FLAG: begin
          if (w_done) begin
            if (ctl_rd_data == READY_MAGIC) begin
              r_word     <= '0;
              r_state    <= RD_BLOCK;
              r_req      <= 1'b1;
              r_req_wr   <= 1'b0;
              r_req_addr <= BLOCK_ADDR;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_timeout) begin
            r_state <= IDLE;
          end
        end

        RD_BLOCK: begin
          if (w_done) begin
            r_out_valid <= 1'b1;
            r_out_data  <= ctl_rd_data;
            if (r_word == WORD_W'(BLOCK_WORDS - 1)) begin
              r_last_word <= 1'b1;
              r_state     <= WR_ACK;
              r_req       <= 1'b1;
              r_req_wr    <= 1'b1;
              r_req_addr  <= HW_FLAG_ADDR;
              r_req_data  <= ACK_MAGIC;
            end else begin
              r_word     <= w_word_next;
              r_req      <= 1'b1;
              r_req_wr   <= 1'b0;
              r_req_addr <= w_next_word_addr;
            end
          end else if (w_timeout) begin
            r_state <= IDLE;
          end
        end

        WR_ACK: begin
          if (w_done || w_timeout) begin
            r_state <= IDLE;
          end
        end

        WR_NONCE: begin
          if (w_done) begin
            r_state    <= WR_SOLFLAG;
            r_req      <= 1'b1;
            r_req_wr   <= 1'b1;
            r_req_addr <= HW_FLAG_ADDR;
            r_req_data <= SOL_MAGIC;
          end else if (w_timeout) begin
            r_state <= IDLE;
          end
        end

        WR_SOLFLAG: begin
          if (w_done) begin
            r_state        <= IDLE;
            r_sol_pending  <= 1'b0;
            r_sol_response <= SOL_WRITTEN;
          end else if (w_timeout) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase

      // Claims are accepted in any state; a new claim overrides the
      // written response of a simultaneously completing solution write.
      if (sol_claim) begin
        if (!w_pending_eff) begin
          r_nonce        <= in_data;
          r_sol_pending  <= 1'b1;
          r_sol_response <= SOL_ACCEPTED;
        end else begin
          r_sol_response <= SOL_DROPPED;
        end
      end
    end
  end

endmodule

// File: doc/mailbox_mem_manager.md
Name: mailbox_mem_manager

Overview:
Parametrised successor to the single-register poller. Polls the host mailbox flag in shared DDR through the master RAM controller. On the ready magic it streams a BLOCK_WORDS work block to the mining core, then acknowledges. It also writes core-claimed solutions (nonce plus flag) back to memory, with a response timeout on every controller transaction.

Parameters:
ADDR_W, 28, controller address width
DATA_W, 32, controller data width
BASE_ADDR, 28'h8000000, mailbox base; host flag at +0, hardware flag at +4, block at +8
BLOCK_WORDS, 24, work-block length in words; nonce slot at BASE_ADDR+8+4*BLOCK_WORDS
READY_MAGIC, 32'hAAAA0000, host "new work" value
ACK_MAGIC, 32'h5555AAAA, written to hardware flag after block load
SOL_MAGIC, 32'h5555F00D, written to hardware flag after a nonce write
POLL_GAP, 16, idle cycles between flag polls (>=1)
TIMEOUT, 1024, max cycles waiting for controller response

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ctl_go  out  1  one-cycle transaction request to RAM controller
ctl_wr  out  1  1=write, 0=read; valid with ctl_go
ctl_address  out  ADDR_W  byte address; held until response
ctl_wr_data  out  DATA_W  write data; held until response
ctl_rd_valid  in  1  read data available (read_user_data_available)
ctl_rd_data  in  DATA_W  read data
ctl_wr_done  in  1  write complete (write_control_done)
out_valid  out  1  block word valid to core
out_data  out  DATA_W  block word, word 0 first
start_found  out  1  one-cycle pulse: full block delivered
sol_claim  in  1  core presents solution (level sampled, one-cycle pulse expected)
in_data  in  DATA_W  nonce, valid with sol_claim
sol_response  out  2  00 none, 01 accepted, 10 written, 11 dropped
err_timeout  out  1  sticky; set on any controller timeout; cleared by reset only

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, state IDLE, sol_pending=0, word counter 0, gap counter 0.
- Transaction primitive: ctl_go high exactly one cycle on entry to a request state. Address/data/ctl_wr held until ctl_rd_valid (read) or ctl_wr_done (write). Response in the ctl_go cycle is ignored.
- Timeout: response wait counter reaches TIMEOUT -> err_timeout=1. Abort to IDLE; a pending solution is retained.
- IDLE: counts POLL_GAP cycles. If sol_pending -> WR_NONCE, which takes priority over polling. Else when gap expires -> RD_FLAG.
- RD_FLAG: read BASE_ADDR. Data==READY_MAGIC -> RD_BLOCK with word counter=0. Else -> IDLE.
- RD_BLOCK: read BASE_ADDR+8+4*k for k=0..BLOCK_WORDS-1, one transaction per word. Each ctl_rd_valid gives out_valid=1 for one cycle with out_data=ctl_rd_data. After the last word -> WR_ACK.
- start_found pulses the cycle after the last word's out_valid.
- WR_ACK: write ACK_MAGIC to BASE_ADDR+4; done -> IDLE.
- WR_NONCE: write held nonce to nonce slot; done -> WR_SOLFLAG.
- WR_SOLFLAG: write SOL_MAGIC to BASE_ADDR+4; done -> sol_response=10 for one cycle, sol_pending=0 -> IDLE.
- Solution capture (any state): sol_claim with sol_pending=0 -> latch in_data, sol_pending=1, sol_response=01 for one cycle. sol_claim with sol_pending=1 -> sol_response=11 for one cycle; data discarded, first nonce kept.
- sol_claim in the same cycle as completion of WR_SOLFLAG counts as new (pending frees first). Response 01 wins the output that cycle and the 10 is lost; this is documented, not an error.
- Claims during RD_BLOCK are latched and serviced after the block and WR_ACK complete; the block is never interrupted.
- Address arithmetic in ADDR_W bits, wrapping modulo 2^ADDR_W; no overflow flag.
- Counters sized $clog2 of their maximum plus 1.

Decomposition:
- Package mailbox_mm_pkg: state enum {IDLE, RD_FLAG, RD_BLOCK, WR_ACK, WR_NONCE, WR_SOLFLAG}, sol_response encodings, offsets HOST_FLAG_OFS=0, HW_FLAG_OFS=4, BLOCK_OFS=8.
- Sub-module mm_txn: owns the ctl_go pulse, the hold of address/data, the response wait and the timeout counter. Returns done and timeout to the FSM.

Test Plan:
- Flag read returns 32'h00000000 -> no block reads. Next poll comes POLL_GAP cycles after return to IDLE. ctl_go never asserted with ctl_wr=1.
- Flag read returns 32'hAAAA0000, block words 0..23 = 32'h1000+k with random 0-5 cycle latency -> 24 out_valid pulses in order at addresses 28'h8000008..28'h8000064 step 4. Then start_found once, then write 32'h5555AAAA to 28'h8000004.
- sol_claim with in_data=32'hDEADBEEF while IDLE -> sol_response 01. Then write DEADBEEF to 28'h8000068, then 5555F00D to 28'h8000004, then sol_response 10.
- Second sol_claim (32'h12345678) while first pending -> sol_response 11. Only DEADBEEF is written.
- Claim mid-RD_BLOCK -> block completes uninterrupted, WR_ACK, then nonce write.
- ctl_rd_valid withheld for TIMEOUT cycles -> err_timeout=1 and return to IDLE. Assert async reset mid-RD_BLOCK -> all outputs 0 immediately, and after release polling restarts at 28'h8000000.
